lbm_bank_mgr: RTL and testbench

Parametrised successor to the single-purpose LBM memory manager. It owns N_CH pairs of distribution BRAMs: bank A and bank B per lattice direction. It arbitrates between the LBM solver's logical current/next ports and an internal block engine. The engine performs ping-pong bank swaps, next-to-current block copies and next-bank clears, all addressed per block index.

---
 rtl/lbm_bank_mgr_if.sv | 14 +
 rtl/lbm_bank_mgr.sv | 163 ++++++++++++++++
 tb/tb_lbm_bank_mgr.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lbm_bank_mgr_if.sv
// rtl/lbm_bank_mgr_if.sv - request/status handshake between the LBM sequencer and the bank manager
interface lbm_bank_mgr_if #(
  parameter int BLK_IDX_WIDTH = 4
);
  logic                     swap_req;
  logic [1:0]               swap_mode;
  logic [BLK_IDX_WIDTH-1:0] block_index;
  logic                     busy;
  logic                     done;
  logic                     bank_sel;

  modport master (output swap_req, swap_mode, block_index, input busy, done, bank_sel);
  modport slave  (input swap_req, swap_mode, block_index, output busy, done, bank_sel);
endinterface

// File: rtl/lbm_bank_mgr.sv
// rtl/lbm_bank_mgr.sv - A/B distribution bank manager with ping-pong, block copy and block clear engine
module lbm_bank_mgr #(
  parameter int N_CH           = 9,
  parameter int DATA_WIDTH     = 16,
  parameter int BLK_IDX_WIDTH  = 4,
  parameter int BLK_DEPTH_LOG2 = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  lbm_bank_mgr_if.slave                ctl,
  input  logic [N_CH*ADDR_WIDTH-1:0]   solver_cur_addr,
  input  logic [N_CH*DATA_WIDTH-1:0]   solver_cur_data_in,
  input  logic [N_CH-1:0]              solver_cur_we,
  output logic [N_CH*DATA_WIDTH-1:0]   solver_cur_data_out,
  input  logic [N_CH*ADDR_WIDTH-1:0]   solver_nxt_addr,
  input  logic [N_CH*DATA_WIDTH-1:0]   solver_nxt_data_in,
  input  logic [N_CH-1:0]              solver_nxt_we,
  output logic [N_CH*DATA_WIDTH-1:0]   solver_nxt_data_out,
  output logic [N_CH*ADDR_WIDTH-1:0]   a_addr,
  output logic [N_CH*DATA_WIDTH-1:0]   a_data_in,
  output logic [N_CH-1:0]              a_we,
  input  logic [N_CH*DATA_WIDTH-1:0]   a_data_out,
  output logic [N_CH*ADDR_WIDTH-1:0]   b_addr,
  output logic [N_CH*DATA_WIDTH-1:0]   b_data_in,
  output logic [N_CH-1:0]              b_we,
  input  logic [N_CH*DATA_WIDTH-1:0]   b_data_out
);
  localparam int CW = BLK_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] LAST_K     = CW'((1 << BLK_DEPTH_LOG2) - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'((1 << BLK_DEPTH_LOG2) - 1 + READ_LATENCY);
  localparam logic [1:0] MODE_PP = 2'd0, MODE_COPY = 2'd1, MODE_CLEAR = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_PP, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                                        state_q, state_d;
  logic [1:0]                                    mode_q, mode_d;
  logic [BLK_IDX_WIDTH-1:0]                      blk_q, blk_d;
  logic [CW-1:0]                                 cnt_q, cnt_d;
  logic                                          bank_sel_q, bank_sel_d;
  logic [READ_LATENCY-1:0]                       rd_sel_q, rd_sel_d;
  logic [READ_LATENCY-1:0]                       cp_vld_q, cp_vld_d;
  logic [READ_LATENCY-1:0][BLK_DEPTH_LOG2-1:0]   cp_off_q, cp_off_d;

  // Nop shares the two-cycle PP path so its latency matches ping-pong; only mode 0 toggles.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    bank_sel_d = bank_sel_q;
    case (state_q)
      S_IDLE: if (ctl.swap_req) begin
        mode_d  = ctl.swap_mode;
        blk_d   = ctl.block_index;
        cnt_d   = '0;
        state_d = (ctl.swap_mode == MODE_COPY || ctl.swap_mode == MODE_CLEAR) ? S_RUN : S_PP;
      end
      S_PP: begin
        if (mode_q == MODE_PP) bank_sel_d = ~bank_sel_q;
        state_d = S_FIN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_K) state_d = (mode_q == MODE_COPY) ? S_DRAIN : S_FIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_DRAIN) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay lines: bank_sel behind solver reads, copy write offset behind engine reads.
  always_comb begin
    rd_sel_d    = rd_sel_q;
    cp_vld_d    = cp_vld_q;
    cp_off_d    = cp_off_q;
    rd_sel_d[0] = bank_sel_q;
    cp_vld_d[0] = (state_q == S_RUN) && (mode_q == MODE_COPY);
    cp_off_d[0] = cnt_q[BLK_DEPTH_LOG2-1:0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_sel_d[i] = rd_sel_q[i-1];
      cp_vld_d[i] = cp_vld_q[i-1];
      cp_off_d[i] = cp_off_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      blk_q      <= '0;
      cnt_q      <= '0;
      bank_sel_q <= 1'b0;
      rd_sel_q   <= '0;
      cp_vld_q   <= '0;
      cp_off_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      blk_q      <= blk_d;
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      rd_sel_q   <= rd_sel_d;
      cp_vld_q   <= cp_vld_d;
      cp_off_q   <= cp_off_d;
    end
  end

  assign ctl.busy     = (state_q != S_IDLE);
  assign ctl.done     = (state_q == S_FIN);
  assign ctl.bank_sel = bank_sel_q;

  assign solver_cur_data_out = rd_sel_q[READ_LATENCY-1] ? b_data_out : a_data_out;
  assign solver_nxt_data_out = rd_sel_q[READ_LATENCY-1] ? a_data_out : b_data_out;

  logic [ADDR_WIDTH-1:0]          eng_rd_addr, eng_wr_addr;
  logic [N_CH*DATA_WIDTH-1:0]     nxt_phys_dout;
  logic                           clr_wr, cp_wr;

  assign eng_rd_addr   = {blk_q, cnt_q[BLK_DEPTH_LOG2-1:0]};
  assign eng_wr_addr   = {blk_q, cp_off_q[READ_LATENCY-1]};
  assign nxt_phys_dout = bank_sel_q ? a_data_out : b_data_out;
  assign clr_wr        = (state_q == S_RUN) && (mode_q == MODE_CLEAR);
  assign cp_wr         = cp_vld_q[READ_LATENCY-1];

  always_comb begin
    a_addr    = '0;
    a_data_in = '0;
    a_we      = '0;
    b_addr    = '0;
    b_data_in = '0;
    b_we      = '0;
    if (state_q == S_IDLE) begin
      a_addr    = bank_sel_q ? solver_nxt_addr    : solver_cur_addr;
      a_data_in = bank_sel_q ? solver_nxt_data_in : solver_cur_data_in;
      a_we      = bank_sel_q ? solver_nxt_we      : solver_cur_we;
      b_addr    = bank_sel_q ? solver_cur_addr    : solver_nxt_addr;
      b_data_in = bank_sel_q ? solver_cur_data_in : solver_nxt_data_in;
      b_we      = bank_sel_q ? solver_cur_we      : solver_nxt_we;
    end else if (bank_sel_q) begin
      a_addr    = {N_CH{eng_rd_addr}};
      a_we      = {N_CH{clr_wr}};
      b_addr    = {N_CH{eng_wr_addr}};
      b_data_in = nxt_phys_dout;
      b_we      = {N_CH{cp_wr}};
    end else begin
      b_addr    = {N_CH{eng_rd_addr}};
      b_we      = {N_CH{clr_wr}};
      a_addr    = {N_CH{eng_wr_addr}};
      a_data_in = nxt_phys_dout;
      a_we      = {N_CH{cp_wr}};
    end
    if (!rst) begin
      a_we = '0;
      b_we = '0;
    end
  end
endmodule

// File: tb/tb_lbm_bank_mgr.sv
// tb/tb_lbm_bank_mgr.sv - directed self-checking bench for lbm_bank_mgr
module tb_lbm_bank_mgr;
  localparam int N_CH = 9, DW = 16, BIW = 4, BDL = 2, AW = 6, RL = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lbm_bank_mgr_if #(.BLK_IDX_WIDTH(BIW)) ctl ();

  logic [N_CH*AW-1:0] solver_cur_addr, solver_nxt_addr, a_addr, b_addr;
  logic [N_CH*DW-1:0] solver_cur_data_in, solver_nxt_data_in, solver_cur_data_out, solver_nxt_data_out;
  logic [N_CH*DW-1:0] a_data_in, b_data_in, a_data_out, b_data_out;
  logic [N_CH-1:0]    solver_cur_we, solver_nxt_we, a_we, b_we;

  lbm_bank_mgr #(
    .N_CH(N_CH), .DATA_WIDTH(DW), .BLK_IDX_WIDTH(BIW), .BLK_DEPTH_LOG2(BDL),
    .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .ctl(ctl),
    .solver_cur_addr(solver_cur_addr), .solver_cur_data_in(solver_cur_data_in),
    .solver_cur_we(solver_cur_we), .solver_cur_data_out(solver_cur_data_out),
    .solver_nxt_addr(solver_nxt_addr), .solver_nxt_data_in(solver_nxt_data_in),
    .solver_nxt_we(solver_nxt_we), .solver_nxt_data_out(solver_nxt_data_out),
    .a_addr(a_addr), .a_data_in(a_data_in), .a_we(a_we), .a_data_out(a_data_out),
    .b_addr(b_addr), .b_data_in(b_data_in), .b_we(b_we), .b_data_out(b_data_out)
  );

  logic [DW-1:0] mem_a [N_CH][64];
  logic [DW-1:0] mem_b [N_CH][64];

  always @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (a_we[c]) mem_a[c][a_addr[c*AW +: AW]] <= a_data_in[c*DW +: DW];
      if (b_we[c]) mem_b[c][b_addr[c*AW +: AW]] <= b_data_in[c*DW +: DW];
      a_data_out[c*DW +: DW] <= mem_a[c][a_addr[c*AW +: AW]];
      b_data_out[c*DW +: DW] <= mem_b[c][b_addr[c*AW +: AW]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input bit nxt, input int addr, input logic [DW-1:0] d);
    logic [AW-1:0] ad;
    ad = addr[AW-1:0];
    if (nxt) begin
      solver_nxt_addr = {N_CH{ad}}; solver_nxt_data_in = {N_CH{d}}; solver_nxt_we = '1;
    end else begin
      solver_cur_addr = {N_CH{ad}}; solver_cur_data_in = {N_CH{d}}; solver_cur_we = '1;
    end
    tick();
    solver_nxt_we = '0;
    solver_cur_we = '0;
  endtask

  task automatic run_req(input logic [1:0] mode, input logic [BIW-1:0] blk,
                         input bit nxt_we_busy, output int cyc);
    ctl.swap_req = 1'b1; ctl.swap_mode = mode; ctl.block_index = blk;
    tick();
    ctl.swap_req = 1'b0;
    cyc = 1;
    if (nxt_we_busy) solver_nxt_we = '1;
    while (!ctl.done && cyc < 100) begin
      tick();
      cyc++;
    end
    solver_nxt_we = '0;
    tick();
  endtask

  int cyc, dones;

  initial begin
    rst = 1'b0;
    ctl.swap_req = 1'b0; ctl.swap_mode = 2'd3; ctl.block_index = '0;
    solver_cur_addr = '0; solver_cur_data_in = '1; solver_cur_we = '1;
    solver_nxt_addr = '0; solver_nxt_data_in = '1; solver_nxt_we = '1;
    @(negedge clk);
    check("rst_a_we", 32'(a_we), 32'h0);
    check("rst_b_we", 32'(b_we), 32'h0);
    tick();
    solver_cur_we = '0; solver_nxt_we = '0; rst = 1'b1;
    check("rst_bank_sel", 32'(ctl.bank_sel), 0);
    check("rst_busy", 32'(ctl.busy), 0);
    check("rst_done", 32'(ctl.done), 0);

    // Pingpong: cur port writes bank A before, bank B after
    sw(0, 5, 16'h1111);
    ctl.swap_req = 1'b1; ctl.swap_mode = 2'd0; ctl.block_index = 4'd0;
    tick();
    ctl.swap_req = 1'b0;
    check("pp_busy_c1", 32'(ctl.busy), 1);
    check("pp_done_c1", 32'(ctl.done), 0);
    tick();
    check("pp_busy_c2", 32'(ctl.busy), 1);
    check("pp_done_c2", 32'(ctl.done), 1);
    check("pp_bank_sel", 32'(ctl.bank_sel), 1);
    tick();
    check("pp_busy_c3", 32'(ctl.busy), 0);
    check("pp_done_c3", 32'(ctl.done), 0);
    sw(0, 5, 16'hABCD);
    check("pp_wr_b", 32'(mem_b[0][5]), 32'hABCD);
    check("pp_a_kept", 32'(mem_a[0][5]), 32'h1111);
    solver_cur_addr = {N_CH{6'd5}};
    tick();
    check("pp_rd_cur", 32'(solver_cur_data_out[DW-1:0]), 32'hABCD);

    run_req(2'd0, 4'd0, 0, cyc);
    check("pp2_latency", 32'(cyc), 2);
    check("pp2_bank_sel", 32'(ctl.bank_sel), 0);

    // Copy block 3: next (B) -> cur (A)
    for (int i = 0; i < 4; i++) begin
      sw(1, 12 + i, 16'(16'h10 + i));
      sw(0, 12 + i, 16'h0);
    end
    sw(0, 11, 16'h5511);
    sw(0, 16, 16'h6616);
    run_req(2'd1, 4'd3, 0, cyc);
    check("cp_latency", 32'(cyc), 6);
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < 4; i++)
        check($sformatf("cp_a_ch%0d_%0d", c, 12 + i), 32'(mem_a[c][12+i]), 32'h10 + i);
    check("cp_a_11", 32'(mem_a[4][11]), 32'h5511);
    check("cp_a_16", 32'(mem_a[8][16]), 32'h6616);
    check("cp_bank_sel", 32'(ctl.bank_sel), 0);

    // Clear block 1 of next (B), solver next writes during busy must be dropped
    for (int i = 3; i < 9; i++) sw(1, i, 16'hFFFF);
    sw(1, 40, 16'h1234);
    solver_nxt_addr = {N_CH{6'd40}}; solver_nxt_data_in = {N_CH{16'h7777}};
    run_req(2'd2, 4'd1, 1, cyc);
    check("clr_latency", 32'(cyc), 5);
    for (int c = 0; c < N_CH; c++)
      for (int i = 4; i < 8; i++)
        check($sformatf("clr_b_ch%0d_%0d", c, i), 32'(mem_b[c][i]), 32'h0);
    check("clr_b_3", 32'(mem_b[2][3]), 32'hFFFF);
    check("clr_b_8", 32'(mem_b[6][8]), 32'hFFFF);
    check("clr_solver_masked", 32'(mem_b[0][40]), 32'h1234);

    // Pingpong request during a copy is ignored
    ctl.swap_req = 1'b1; ctl.swap_mode = 2'd1; ctl.block_index = 4'd3;
    tick();
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        ctl.swap_req = 1'b1; ctl.swap_mode = 2'd0;
      end else begin
        ctl.swap_req = 1'b0;
      end
      if (ctl.done) dones++;
      tick();
    end
    ctl.swap_req = 1'b0;
    check("ign_dones", 32'(dones), 1);
    check("ign_bank_sel", 32'(ctl.bank_sel), 0);
    check("ign_busy", 32'(ctl.busy), 0);

    // Reset during 2nd RUN cycle of a copy with bank_sel=1 (next=A, cur=B)
    run_req(2'd0, 4'd0, 0, cyc);
    check("rr_bank_sel_pre", 32'(ctl.bank_sel), 1);
    for (int i = 0; i < 4; i++) begin
      sw(1, 8 + i, 16'(16'h20 + i));
      sw(0, 8 + i, 16'hEEEE);
    end
    ctl.swap_req = 1'b1; ctl.swap_mode = 2'd1; ctl.block_index = 4'd2;
    tick();
    ctl.swap_req = 1'b0;
    tick();
    check("rr_b_we_pending", 32'(b_we), 32'h1FF);
    rst = 1'b0;
    #1;
    check("rr_b_we_forced", 32'(b_we), 0);
    check("rr_a_we_forced", 32'(a_we), 0);
    tick();
    rst = 1'b1;
    check("rr_busy", 32'(ctl.busy), 0);
    check("rr_bank_sel", 32'(ctl.bank_sel), 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (ctl.done) dones++;
      tick();
    end
    check("rr_no_done", 32'(dones), 0);
    check("rr_b8_kept", 32'(mem_b[0][8]), 32'hEEEE);
    check("rr_b9_kept", 32'(mem_b[5][9]), 32'hEEEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
